// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving NUM_MASTERS byte-wide masters shared access to a
// synchronous single-port RAM and a small I/O block. The winner's access is
// presented combinationally in the grant cycle. Read data comes back one cycle
// later, tagged by m_rvalid.
module mem_bus_arbiter #(
   parameter int unsigned NUM_MASTERS    = 3,
   parameter int unsigned RAM_ADDR_WIDTH = 17,
   parameter int unsigned MAX_BURST      = 4,
   parameter int unsigned PRIO0          = 0
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [32*NUM_MASTERS-1:0]     m_addr,
   input  logic [NUM_MASTERS-1:0]        m_wr,
   input  logic [8*NUM_MASTERS-1:0]      m_wdata,
   output logic [NUM_MASTERS-1:0]        m_gnt,
   output logic [7:0]                    m_rdata,
   output logic [NUM_MASTERS-1:0]        m_rvalid,
   output logic                          ram_we,
   output logic [RAM_ADDR_WIDTH-1:0]     ram_addr,
   output logic [7:0]                    ram_din,
   input  logic [7:0]                    ram_dout,
   output logic                          io_en,
   output logic                          io_wr,
   output logic [2:0]                    io_sel,
   output logic [7:0]                    io_din,
   input  logic [7:0]                    io_dout,
   input  logic                          io_full
);

   localparam int unsigned IdxW     = (NUM_MASTERS > 2) ? 2 : 1;
   localparam logic [3:0]  MaxBurst = 4'(MAX_BURST);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_MASTERS - 1);

   typedef logic [IdxW-1:0] idx_t;

   logic [31:0]            addr_arr  [NUM_MASTERS];
   logic [7:0]             wdata_arr [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] is_io;
   logic [NUM_MASTERS-1:0] elig;

   idx_t       rr_ptr_q, rr_ptr_d;
   logic [3:0] burst_cnt_q, burst_cnt_d;
   logic       rd_valid_q, rd_valid_d;
   idx_t       rd_owner_q, rd_owner_d;
   logic       rd_src_q, rd_src_d;

   logic        win_vld;
   idx_t        win_idx;
   logic [31:0] win_addr;
   logic [7:0]  win_wdata;
   logic        win_wr;
   logic        win_io;

   logic unused_addr_hi;
   assign unused_addr_hi = ^win_addr[31:RAM_ADDR_WIDTH];

   // Split the flat buses per master, decode region and mask blocked IO writes.
   // Nothing is eligible while reset is held so the granted path stays quiet.
   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         addr_arr[i]  = m_addr[32*i +: 32];
         wdata_arr[i] = m_wdata[8*i +: 8];
         is_io[i]     = (addr_arr[i][RAM_ADDR_WIDTH -: 2] == 2'b11);
         elig[i]      = rst_n_in & m_req[i] & ~(is_io[i] & m_wr[i] & io_full);
      end
   end

   // Pick the winner: master-0 priority, then burst lock, then round-robin.
   always_comb begin
      idx_t cand;
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      if ((PRIO0 != 0) && elig[0]) begin
         win_vld = 1'b1;
         win_idx = '0;
      end else if ((burst_cnt_q != 4'd0) && (burst_cnt_q < MaxBurst) && elig[rr_ptr_q]) begin
         // burst_cnt_q == 0 means the last cycle was idle: no owner to keep.
         win_vld = 1'b1;
         win_idx = rr_ptr_q;
      end else begin
         // Search starts after rr_ptr and wraps, so the current owner comes last.
         for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = idx_t'((32'(rr_ptr_q) + k) % NUM_MASTERS);
            if (!win_vld && elig[cand]) begin
               win_vld = 1'b1;
               win_idx = cand;
            end
         end
      end
   end

   // Route the winning master's request fields.
   always_comb begin
      win_addr  = addr_arr[win_idx];
      win_wdata = wdata_arr[win_idx];
      win_wr    = m_wr[win_idx];
      win_io    = is_io[win_idx];
   end

   // Next-state for round-robin pointer, burst counter and read-return tag.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = 4'd0;
      rd_valid_d  = 1'b0;
      rd_owner_d  = rd_owner_q;
      rd_src_d    = rd_src_q;
      if (win_vld) begin
         rr_ptr_d = win_idx;
         // A repeat grant at the limit (nobody else eligible) restarts the count.
         if ((win_idx == rr_ptr_q) && (burst_cnt_q != 4'd0) && (burst_cnt_q < MaxBurst)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
         end else begin
            burst_cnt_d = 4'd1;
         end
         if (!win_wr) begin
            rd_valid_d = 1'b1;
            rd_owner_d = win_idx;
            rd_src_d   = win_io;
         end
      end
   end

   // Arbitration and read-return state.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rr_ptr_q    <= LastIdx;
         burst_cnt_q <= 4'd0;
         rd_valid_q  <= 1'b0;
         rd_owner_q  <= '0;
         rd_src_q    <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         rd_valid_q  <= rd_valid_d;
         rd_owner_q  <= rd_owner_d;
         rd_src_q    <= rd_src_d;
      end
   end

   // Drive the grant and the RAM or IO access; everything reads zero when idle.
   always_comb begin
      m_gnt    = '0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      io_en    = 1'b0;
      io_wr    = 1'b0;
      io_sel   = '0;
      io_din   = '0;
      if (win_vld) begin
         m_gnt[win_idx] = 1'b1;
         if (win_io) begin
            io_en  = 1'b1;
            io_wr  = win_wr;
            io_sel = win_addr[2:0];
            io_din = win_wdata;
         end else begin
            ram_we   = win_wr;
            ram_addr = win_addr[RAM_ADDR_WIDTH-1:0];
            ram_din  = win_wdata;
         end
      end
   end

   // Return read data to the master that issued last cycle's read.
   always_comb begin
      m_rvalid = '0;
      if (rd_valid_q) begin
         m_rvalid[rd_owner_q] = 1'b1;
      end
      m_rdata = rd_src_q ? io_dout : ram_dout;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural arbitration model.
// A second instance with PRIO0=1 shares all inputs.
module tb_mem_bus_arbiter;

   localparam int N   = 3;
   localparam int MAXB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [32*N-1:0] addr;
   logic [N-1:0]  wr;
   logic [8*N-1:0] wdata;
   logic [7:0]    ram_dout;
   logic [7:0]    io_dout;
   logic          io_full;

   logic [N-1:0]  gnt, rvalid;
   logic [7:0]    rdata;
   logic          ram_we;
   logic [16:0]   ram_addr;
   logic [7:0]    ram_din;
   logic          io_en, io_wr;
   logic [2:0]    io_sel;
   logic [7:0]    io_din;

   logic [N-1:0]  p_gnt;
   logic [N-1:0]  p_unused_rvalid;
   logic [7:0]    p_unused_rdata, p_unused_ram_din, p_unused_io_din;
   logic          p_unused_ram_we, p_unused_io_en, p_unused_io_wr;
   logic [16:0]   p_unused_ram_addr;
   logic [2:0]    p_unused_io_sel;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .NUM_MASTERS(N), .RAM_ADDR_WIDTH(17), .MAX_BURST(MAXB), .PRIO0(0)
   ) u_dut (
      .clk_in(clk), .rst_n_in(rst_n), .m_req(req), .m_addr(addr), .m_wr(wr),
      .m_wdata(wdata), .m_gnt(gnt), .m_rdata(rdata), .m_rvalid(rvalid),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .io_en(io_en), .io_wr(io_wr), .io_sel(io_sel), .io_din(io_din),
      .io_dout(io_dout), .io_full(io_full)
   );

   mem_bus_arbiter #(
      .NUM_MASTERS(N), .RAM_ADDR_WIDTH(17), .MAX_BURST(MAXB), .PRIO0(1)
   ) u_dut_prio (
      .clk_in(clk), .rst_n_in(rst_n), .m_req(req), .m_addr(addr), .m_wr(wr),
      .m_wdata(wdata), .m_gnt(p_gnt), .m_rdata(p_unused_rdata), .m_rvalid(p_unused_rvalid),
      .ram_we(p_unused_ram_we), .ram_addr(p_unused_ram_addr), .ram_din(p_unused_ram_din),
      .ram_dout(ram_dout), .io_en(p_unused_io_en), .io_wr(p_unused_io_wr),
      .io_sel(p_unused_io_sel), .io_din(p_unused_io_din), .io_dout(io_dout),
      .io_full(io_full)
   );

   // Synchronous single-port RAM behind the main instance.
   logic [7:0] ram [0:131071];
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic set_m(input int i, input logic r, input logic [31:0] a, input logic w,
                        input logic [7:0] d);
      req[i]           = r;
      addr[32*i +: 32] = a;
      wr[i]            = w;
      wdata[8*i +: 8]  = d;
   endtask

   task automatic clr_all();
      req   = '0;
      addr  = '0;
      wr    = '0;
      wdata = '0;
   endtask

   // Returns at a falling edge with reset just released; caller drives inputs next.
   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      io_full = 1'b0;
      io_dout = 8'h00;
      clr_all();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- behavioural model ----------------
   int         mrr     [2];
   int         mstreak [2];
   bit         pv, psrc, pknown;
   int         powner;
   logic [7:0] pdata;
   logic [7:0] mmem [int];

   function automatic bit is_io_a(input logic [31:0] a);
      return a[17:16] == 2'b11;
   endfunction

   task automatic model_reset();
      mrr[0] = N - 1; mrr[1] = N - 1;
      mstreak[0] = 0; mstreak[1] = 0;
      pv = 1'b0;
   endtask

   // Winner by the arbitration rules; -1 when nobody is eligible.
   function automatic int pick(input int md);
      bit e [N];
      for (int i = 0; i < N; i++)
         e[i] = req[i] && !(is_io_a(addr[32*i +: 32]) && wr[i] && io_full);
      if (md == 1 && e[0]) return 0;
      if (mstreak[md] > 0 && mstreak[md] < MAXB && e[mrr[md]]) return mrr[md];
      for (int k = 1; k <= N; k++)
         if (e[(mrr[md] + k) % N]) return (mrr[md] + k) % N;
      return -1;
   endfunction

   task automatic rand_inputs();
      for (int i = 0; i < N; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(3) == 0) begin
            a[17:16] = 2'b11;
         end else begin
            a[17:16] = 2'($urandom_range(2));
            a[15:0]  = {12'h000, 4'($urandom_range(15))};
         end
         set_m(i, ($urandom_range(9) < 7), a, 1'($urandom_range(1)), 8'($urandom));
      end
   endtask

   task automatic rand_cycle();
      int          w [2];
      logic [31:0] a;
      logic        io;
      logic [N-1:0] eg, pg, ev;
      @(negedge clk);
      rst_n = ($urandom_range(63) != 0);
      if ($urandom_range(3) != 0) rand_inputs();
      io_full = ($urandom_range(3) == 0);
      io_dout = 8'($urandom);
      #1;
      for (int md = 0; md < 2; md++) w[md] = rst_n ? pick(md) : -1;
      eg = '0; pg = '0; ev = '0;
      a  = '0; io = 1'b0;
      if (w[0] >= 0) begin
         eg[w[0]] = 1'b1;
         a  = addr[32*w[0] +: 32];
         io = is_io_a(a);
      end
      if (w[1] >= 0) pg[w[1]] = 1'b1;
      chk("rnd gnt", gnt, eg);
      chk("rnd prio gnt", p_gnt, pg);
      if (w[0] < 0)
         chk("rnd idle outputs", {ram_we, ram_addr, ram_din, io_en, io_wr, io_sel, io_din}, 0);
      else if (io)
         chk("rnd io path", {io_en, io_wr, io_sel, io_din, ram_we},
             {1'b1, wr[w[0]], a[2:0], wdata[8*w[0] +: 8], 1'b0});
      else
         chk("rnd ram path", {ram_we, ram_addr, ram_din, io_en, io_wr},
             {wr[w[0]], a[16:0], wdata[8*w[0] +: 8], 2'b00});
      if (rst_n && pv) ev[powner] = 1'b1;
      chk("rnd rvalid", rvalid, ev);
      if (rst_n && pv && (psrc || pknown))
         chk("rnd rdata", rdata, psrc ? io_dout : pdata);
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int md = 0; md < 2; md++) begin
            if (w[md] >= 0) begin
               mstreak[md] = (w[md] == mrr[md] && mstreak[md] > 0 && mstreak[md] < MAXB)
                             ? mstreak[md] + 1 : 1;
               mrr[md] = w[md];
            end else begin
               mstreak[md] = 0;
            end
         end
         pv = 1'b0;
         if (w[0] >= 0 && !wr[w[0]]) begin
            pv     = 1'b1;
            powner = w[0];
            psrc   = io;
            pknown = !io && mmem.exists(int'(a[16:0]));
            pdata  = pknown ? mmem[int'(a[16:0])] : 8'h00;
         end
         if (w[0] >= 0 && wr[w[0]] && !io) mmem[int'(a[16:0])] = wdata[8*w[0] +: 8];
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic [N-1:0] req;
      logic         io_full;
      logic [N-1:0] exp_gnt;
      logic [N-1:0] exp_rvalid;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // All three read RAM continuously: bursts of MAX_BURST, then rotate.
      tbl[0]  = '{3'b111, 1'b0, 3'b001, 3'b000};
      tbl[1]  = '{3'b111, 1'b0, 3'b001, 3'b001};
      tbl[2]  = '{3'b111, 1'b0, 3'b001, 3'b001};
      tbl[3]  = '{3'b111, 1'b0, 3'b001, 3'b001};
      tbl[4]  = '{3'b111, 1'b0, 3'b010, 3'b001};
      tbl[5]  = '{3'b111, 1'b0, 3'b010, 3'b010};
      tbl[6]  = '{3'b111, 1'b0, 3'b010, 3'b010};
      tbl[7]  = '{3'b111, 1'b0, 3'b010, 3'b010};
      tbl[8]  = '{3'b111, 1'b0, 3'b100, 3'b010};
      tbl[9]  = '{3'b000, 1'b0, 3'b000, 3'b100};
      tbl[10] = '{3'b000, 1'b0, 3'b000, 3'b000};
      tbl[11] = '{3'b110, 1'b0, 3'b010, 3'b000};
      tbl[12] = '{3'b100, 1'b0, 3'b100, 3'b010};
      tbl[13] = '{3'b100, 1'b1, 3'b100, 3'b100};

      rst_n = 1'b0;
      clr_all();
      io_full = 1'b0;
      io_dout = 8'h00;
      #1;
      chk("reset gnt", gnt, 3'b000);
      chk("reset rvalid", rvalid, 3'b000);
      chk("reset outputs", {ram_we, ram_addr, ram_din, io_en, io_wr, io_sel, io_din}, 0);

      do_reset();
      for (int i = 0; i < N; i++) set_m(i, 1'b0, 32'h10 + 32'(i), 1'b0, 8'h00);
      for (int i = 0; i < 14; i++) begin
         if (i > 0) @(negedge clk);
         req     = tbl[i].req;
         io_full = tbl[i].io_full;
         #1;
         chk($sformatf("vec%0d gnt", i), gnt, tbl[i].exp_gnt);
         chk($sformatf("vec%0d rvalid", i), rvalid, tbl[i].exp_rvalid);
      end

      // Write then read the same RAM byte from another master.
      do_reset();
      set_m(1, 1'b1, 32'h0000_0100, 1'b1, 8'h5A);
      #1;
      chk("wr gnt", gnt, 3'b010);
      chk("wr ram", {ram_we, ram_addr, ram_din}, {1'b1, 17'h00100, 8'h5A});
      @(negedge clk);
      set_m(1, 1'b0, 32'h0, 1'b0, 8'h00);
      set_m(2, 1'b1, 32'h0000_0100, 1'b0, 8'h00);
      #1;
      chk("rd gnt", gnt, 3'b100);
      chk("rd ram", {ram_we, ram_addr}, {1'b0, 17'h00100});
      @(negedge clk);
      clr_all();
      #1;
      chk("rd rvalid", rvalid, 3'b100);
      chk("rd rdata", rdata, 8'h5A);

      // IO write held off by io_full while a RAM read proceeds.
      do_reset();
      io_full = 1'b1;
      set_m(0, 1'b1, 32'h0003_0000, 1'b1, 8'h77);
      set_m(1, 1'b1, 32'h0000_0020, 1'b0, 8'h00);
      #1;
      chk("full gnt", gnt, 3'b010);
      chk("full io_en", io_en, 1'b0);
      @(negedge clk);
      set_m(1, 1'b0, 32'h0, 1'b0, 8'h00);
      #1;
      chk("full idle gnt", gnt, 3'b000);
      chk("full rvalid", rvalid, 3'b010);
      @(negedge clk);
      io_full = 1'b0;
      #1;
      chk("drop gnt", gnt, 3'b001);
      chk("drop io", {io_en, io_wr, io_sel, io_din, ram_we}, {1'b1, 1'b1, 3'd0, 8'h77, 1'b0});

      // IO read returns io_dout, not the RAM byte read in the same cycle.
      do_reset();
      set_m(0, 1'b1, 32'h0000_0000, 1'b1, 8'hC3);
      #1;
      chk("pre wr gnt", gnt, 3'b001);
      @(negedge clk);
      set_m(0, 1'b0, 32'h0, 1'b0, 8'h00);
      set_m(2, 1'b1, 32'h0003_0004, 1'b0, 8'h00);
      io_dout = 8'h41;
      #1;
      chk("io rd gnt", gnt, 3'b100);
      chk("io rd bus", {io_en, io_wr, io_sel, ram_we}, {1'b1, 1'b0, 3'd4, 1'b0});
      @(negedge clk);
      clr_all();
      #1;
      chk("io rd rvalid", rvalid, 3'b100);
      chk("io rd rdata", rdata, 8'h41);

      // Master 0 pre-empts a burst on the priority instance only.
      do_reset();
      set_m(2, 1'b1, 32'h0000_0040, 1'b0, 8'h00);
      #1;
      chk("prio m2 a", p_gnt, 3'b100);
      @(negedge clk);
      #1;
      chk("prio m2 b", p_gnt, 3'b100);
      @(negedge clk);
      set_m(0, 1'b1, 32'h0000_0041, 1'b0, 8'h00);
      #1;
      chk("prio m0 a", p_gnt, 3'b001);
      chk("noprio lock", gnt, 3'b100);
      @(negedge clk);
      #1;
      chk("prio m0 b", p_gnt, 3'b001);
      @(negedge clk);
      set_m(0, 1'b0, 32'h0, 1'b0, 8'h00);
      #1;
      chk("prio resume", p_gnt, 3'b100);

      // Reset right after a granted read discards its return.
      do_reset();
      set_m(1, 1'b1, 32'h0000_0030, 1'b0, 8'h00);
      #1;
      chk("rst rd gnt", gnt, 3'b010);
      @(negedge clk);
      rst_n = 1'b0;
      set_m(1, 1'b0, 32'h0, 1'b0, 8'h00);
      set_m(0, 1'b1, 32'h0000_0031, 1'b0, 8'h00);
      #1;
      chk("in rst rvalid", rvalid, 3'b000);
      chk("in rst gnt", gnt, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_m(i, 1'b1, 32'h50 + 32'(i), 1'b0, 8'h00);
      #1;
      chk("post rst rvalid", rvalid, 3'b000);
      chk("post rst gnt", gnt, 3'b001);

      // Randomized run against the model.
      do_reset();
      model_reset();
      #1;
      for (int c = 0; c < 4000; c++) rand_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of bus masters (legal 2..4).
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 17, RAM address width (128 KiB).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive grants to one master while others wait (legal 1..15).
REQ-004 SHALL have parameter PRIO0, default 0; 1 = master 0 has absolute priority (host-debug mode).
REQ-005 SHALL have clk_in  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have m_req  input  NUM_MASTERS  per-master access request.
REQ-008 SHALL have m_addr  input  32*NUM_MASTERS  per-master byte address; master i at bits [32i+31:32i].
REQ-009 SHALL have m_wr  input  NUM_MASTERS  per-master 1=write, 0=read.
REQ-010 SHALL have m_wdata  input  8*NUM_MASTERS  per-master write byte.
REQ-011 SHALL have m_gnt  output  NUM_MASTERS  one-hot grant; access performed this cycle.
REQ-012 SHALL have m_rdata  output  8  read data, shared by all masters.
REQ-013 SHALL have m_rvalid  output  NUM_MASTERS  one-hot, m_rdata valid for that master.
REQ-014 SHALL have ram_we, ram_addr[RAM_ADDR_WIDTH-1:0], ram_din[7:0] outputs and ram_dout[7:0] input to the synchronous single-port RAM.
REQ-015 SHALL have io_en, io_wr, io_sel[2:0], io_din[7:0] outputs and io_dout[7:0], io_full inputs to the I/O block.

Function
REQ-016 SHALL decode IO region as m_addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11; all other addresses are RAM.
REQ-017 SHALL mask a master's request as ineligible in any cycle it requests an IO write while io_full=1; IO reads and RAM accesses are unaffected.
REQ-018 SHALL select the winner combinationally each cycle from eligible requesters; m_gnt is zero when none is eligible.
REQ-019 SHALL, with PRIO0=1, grant master 0 whenever eligible, overriding lock and round-robin.
REQ-020 SHALL otherwise grant the previous winner again if still eligible and burst_cnt < MAX_BURST, else the first eligible master after rr_ptr in ascending wrap-around order.
REQ-021 SHALL update rr_ptr to the winner index on each grant; burst_cnt increments on a repeat grant to the same master, loads 1 on a grant to a different master, clears to 0 on an idle cycle.
REQ-022 SHALL, when burst_cnt==MAX_BURST and no other master is eligible, grant the current master and reset burst_cnt to 1 (no idle bubble).
REQ-023 SHALL drive, for a granted RAM access: ram_addr=addr[RAM_ADDR_WIDTH-1:0], ram_din=wdata, ram_we=wr; same cycle.
REQ-024 SHALL drive, for a granted IO access: io_en=1, io_sel=addr[2:0], io_din=wdata, io_wr=wr; ram_we=0.
REQ-025 SHALL drive ram_we, io_en, io_wr to 0 and ram_addr, ram_din, io_sel, io_din to 0 in cycles with no grant.
REQ-026 SHALL register, on a granted read, the winner index and region into rd_owner/rd_src; m_rvalid[rd_owner]=1 exactly one cycle later; 0 after writes and idle.
REQ-027 SHALL drive m_rdata = rd_src ? io_dout : ram_dout (latency one cycle, matching synchronous RAM).
REQ-028 SHALL support back-to-back reads from different masters, each m_rvalid in consecutive cycles with the correct owner.
REQ-029 SHALL treat a request withdrawn before grant as never issued; no state change.

Reset
REQ-030 SHALL, while rst_n_in=0, force rr_ptr=NUM_MASTERS-1 (master 0 first), burst_cnt=0, m_rvalid=0, rd_owner=0, rd_src=0, and all granted-path outputs to 0.
REQ-031 SHALL discard a read in flight at reset assertion; no m_rvalid after deassertion for it.
REQ-032 SHALL arbitrate normally from the first rising edge after rst_n_in deasserts.

Verification
REQ-033 Reset release, m_req=3'b111, all RAM reads -> grants 0,0,0,0 (MAX_BURST=4), then 1 four times, then 2; each m_rvalid one cycle after its grant.
REQ-034 Master 1 writes 0x5A to 0x00000100, master 2 reads 0x00000100 next cycle -> ram_we=1 addr 0x100, then m_rvalid=3'b100, m_rdata=0x5A.
REQ-035 Master 0 IO write to 0x00030000 with io_full=1, master 1 RAM read pending -> master 1 granted, master 0 granted the cycle io_full drops, io_sel=0, io_wr=1.
REQ-036 PRIO0=1, master 2 in burst, master 0 asserts req -> m_gnt=3'b001 same cycle; master 2 resumes after master 0 drops req.
REQ-037 IO read from 0x00030004 with io_dout=0x41 -> io_en=1, io_sel=4, next cycle m_rdata=0x41 from IO, not ram_dout.
REQ-038 rst_n_in pulsed low in cycle after a granted read -> m_rvalid stays 0, rr_ptr=NUM_MASTERS-1 after release.
